usb_ep0_sequencer: RTL and testbench

- Hardware control-endpoint sequencer. It acts as a master on the J1 I/O bus in front of the USB SIE register map (ioaddr constants).
- Polls USB_STATUS, classifies completed tokens, drains 8-byte SETUP packets from ENDPO0, and handles SET_ADDRESS autonomously, including the deferred address write after the status stage.
- All other SETUP requests are handed to the J1 CPU via a latched setup packet and a pending flag.
- Bus outputs are OR-combined with the CPU's bus outputs, so every output is 0 when the sequencer is idle.

---
 rtl/usb_ep0_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_usb_ep0_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep0_sequencer.sv
// EP0 control sequencer: polls the SIE, drains SETUP packets, runs SET_ADDRESS itself
// and hands every other request to the CPU. Bus outputs are zero while idle or holding.
module usb_ep0_sequencer #(
  parameter int POLL_DIV = 4,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              usb_reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_rd,
  output logic              io_wr,
  output logic [15:0]       io_dout,
  input  logic [15:0]       io_din,
  output logic              busy,
  output logic              setup_pending,
  input  logic              setup_done,
  output logic [63:0]       setup_data,
  output logic              setup_valid,
  output logic              setup_err,
  output logic              token_event,
  output logic [1:0]        token_type,
  output logic [3:0]        token_endp,
  output logic              addr_pending,
  output logic              addr_set
);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(16'h0040);
  localparam logic [ADDR_W-1:0] A_TOKEN   = ADDR_W'(16'h0042);
  localparam logic [ADDR_W-1:0] A_ADDRESS = ADDR_W'(16'h0044);
  localparam logic [ADDR_W-1:0] A_EPO_CTL = ADDR_W'(16'h0048);
  localparam logic [ADDR_W-1:0] A_EPO_DAT = ADDR_W'(16'h004A);
  localparam logic [ADDR_W-1:0] A_EPI_CTL = ADDR_W'(16'h004C);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_TOKEN, S_CLEAR, S_CHK, S_BYTE,
    S_DECODE, S_ARM, S_STALL, S_SETADDR, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic              ovf_q, ovf_d;
  logic [63:0]       data_q, data_d;
  logic [6:0]        addr_q, addr_d;
  logic              addr_pending_q, addr_pending_d;
  logic              setup_pending_q, setup_pending_d;
  logic [1:0]        tok_type_q, tok_type_d;
  logic [3:0]        tok_endp_q, tok_endp_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic              io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic [15:0]       io_dout_q, io_dout_d;
  logic              busy_q, busy_d;
  logic              setup_valid_q, setup_valid_d;
  logic              setup_err_q, setup_err_d;
  logic              token_event_q, token_event_d;
  logic              addr_set_q, addr_set_d;
  logic              is_setaddr;
  logic              unused_din;

  assign unused_din = ^io_din[15:8];
  assign is_setaddr = (data_q[7:0] == 8'h00) && (data_q[15:8] == 8'h05);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bcnt_d          = bcnt_q;
    ovf_d           = ovf_q;
    data_d          = data_q;
    addr_d          = addr_q;
    addr_pending_d  = addr_pending_q;
    setup_pending_d = setup_pending_q;
    tok_type_d      = tok_type_q;
    tok_endp_d      = tok_endp_q;
    token_event_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != 8'(POLL_DIV - 1)) cnt_d = cnt_q + 8'd1;
        if (enable && !setup_pending_q && cnt_q == 8'(POLL_DIV - 1)) begin
          state_d = S_POLL;
          cnt_d   = 8'd0;
        end
      end
      S_POLL:  state_d = io_din[0] ? S_TOKEN : S_IDLE;
      S_TOKEN: begin
        tok_type_d = io_din[5:4];
        tok_endp_d = io_din[3:0];
        state_d    = S_CLEAR;
      end
      S_CLEAR: begin
        if (tok_type_q == 2'b11 && tok_endp_q == 4'd0) begin
          addr_pending_d = 1'b0;
          bcnt_d         = 4'd0;
          ovf_d          = 1'b0;
          state_d        = S_CHK;
        end else if (tok_type_q == 2'b10 && tok_endp_q == 4'd0 && addr_pending_q) begin
          state_d = S_SETADDR;
        end else begin
          token_event_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_CHK: begin
        if (!io_din[0])           state_d = S_BYTE;
        else if (bcnt_q == 4'd8)  state_d = S_DECODE;
        else                      state_d = S_STALL;
      end
      S_BYTE: begin
        if (bcnt_q[3]) begin
          ovf_d = 1'b1;
        end else begin
          data_d[{bcnt_q[2:0], 3'b000} +: 8] = io_din[7:0];
          bcnt_d = bcnt_q + 4'd1;
        end
        state_d = S_CHK;
      end
      S_DECODE: begin
        if (ovf_q) begin
          state_d = S_STALL;
        end else if (is_setaddr) begin
          addr_d         = data_q[22:16];
          addr_pending_d = 1'b1;
          state_d        = S_ARM;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_ARM, S_STALL: state_d = S_IDLE;
      S_SETADDR: begin
        addr_pending_d = 1'b0;
        state_d        = S_IDLE;
      end
      S_HOLD: begin
        if (setup_done) begin
          setup_pending_d = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state cycle.
    io_addr_d     = '0;
    io_rd_d       = 1'b0;
    io_wr_d       = 1'b0;
    io_dout_d     = 16'h0000;
    case (state_d)
      S_POLL:    begin io_rd_d = 1'b1; io_addr_d = A_STATUS;  end
      S_TOKEN:   begin io_rd_d = 1'b1; io_addr_d = A_TOKEN;   end
      S_CLEAR:   begin io_wr_d = 1'b1; io_addr_d = A_STATUS;  io_dout_d = 16'h0001; end
      S_CHK:     begin io_rd_d = 1'b1; io_addr_d = A_EPO_CTL; end
      S_BYTE:    begin io_rd_d = 1'b1; io_addr_d = A_EPO_DAT; end
      S_ARM:     begin io_wr_d = 1'b1; io_addr_d = A_EPI_CTL; io_dout_d = 16'h0002; end
      S_STALL:   begin io_wr_d = 1'b1; io_addr_d = A_EPI_CTL; io_dout_d = 16'h0004; end
      S_SETADDR: begin io_wr_d = 1'b1; io_addr_d = A_ADDRESS; io_dout_d = {9'b0, addr_q}; end
      default: ;
    endcase
    busy_d        = (state_d != S_IDLE) && (state_d != S_HOLD);
    setup_valid_d = (state_d == S_DECODE) && !ovf_q && !is_setaddr;
    if (setup_valid_d) setup_pending_d = 1'b1;
    setup_err_d   = (state_d == S_STALL);
    addr_set_d    = (state_d == S_SETADDR);
  end

  always_ff @(posedge clk) begin
    if (usb_reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      bcnt_q          <= 4'd0;
      ovf_q           <= 1'b0;
      data_q          <= 64'd0;
      addr_q          <= 7'd0;
      addr_pending_q  <= 1'b0;
      setup_pending_q <= 1'b0;
      tok_type_q      <= 2'b00;
      tok_endp_q      <= 4'd0;
      io_addr_q       <= '0;
      io_rd_q         <= 1'b0;
      io_wr_q         <= 1'b0;
      io_dout_q       <= 16'h0000;
      busy_q          <= 1'b0;
      setup_valid_q   <= 1'b0;
      setup_err_q     <= 1'b0;
      token_event_q   <= 1'b0;
      addr_set_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bcnt_q          <= bcnt_d;
      ovf_q           <= ovf_d;
      data_q          <= data_d;
      addr_q          <= addr_d;
      addr_pending_q  <= addr_pending_d;
      setup_pending_q <= setup_pending_d;
      tok_type_q      <= tok_type_d;
      tok_endp_q      <= tok_endp_d;
      io_addr_q       <= io_addr_d;
      io_rd_q         <= io_rd_d;
      io_wr_q         <= io_wr_d;
      io_dout_q       <= io_dout_d;
      busy_q          <= busy_d;
      setup_valid_q   <= setup_valid_d;
      setup_err_q     <= setup_err_d;
      token_event_q   <= token_event_d;
      addr_set_q      <= addr_set_d;
    end
  end

  assign io_addr       = io_addr_q;
  assign io_rd         = io_rd_q;
  assign io_wr         = io_wr_q;
  assign io_dout       = io_dout_q;
  assign busy          = busy_q;
  assign setup_pending = setup_pending_q;
  assign setup_data    = data_q;
  assign setup_valid   = setup_valid_q;
  assign setup_err     = setup_err_q;
  assign token_event   = token_event_q;
  assign token_type    = tok_type_q;
  assign token_endp    = tok_endp_q;
  assign addr_pending  = addr_pending_q;
  assign addr_set      = addr_set_q;
endmodule

// File: tb/tb_usb_ep0_sequencer.sv
// Bench for usb_ep0_sequencer: a small SIE model answers bus reads, expected bus writes
// are queued as stimulus is posted and matched in order as the sequencer issues them.
module tb_usb_ep0_sequencer;
  localparam logic [15:0] A_STATUS  = 16'h0040;
  localparam logic [15:0] A_TOKEN   = 16'h0042;
  localparam logic [15:0] A_ADDRESS = 16'h0044;
  localparam logic [15:0] A_EPO_CTL = 16'h0048;
  localparam logic [15:0] A_EPO_DAT = 16'h004A;
  localparam logic [15:0] A_EPI_CTL = 16'h004C;

  logic clk = 1'b0;
  logic usb_reset, enable, setup_done;
  logic [15:0] io_addr, io_dout, io_din;
  logic io_rd, io_wr, busy, setup_pending, setup_valid, setup_err;
  logic token_event, addr_pending, addr_set;
  logic [63:0] setup_data;
  logic [1:0]  token_type;
  logic [3:0]  token_endp;

  usb_ep0_sequencer #(.POLL_DIV(4), .ADDR_W(16)) dut (
    .clk(clk), .usb_reset(usb_reset), .enable(enable),
    .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_dout(io_dout), .io_din(io_din),
    .busy(busy), .setup_pending(setup_pending), .setup_done(setup_done),
    .setup_data(setup_data), .setup_valid(setup_valid), .setup_err(setup_err),
    .token_event(token_event), .token_type(token_type), .token_endp(token_endp),
    .addr_pending(addr_pending), .addr_set(addr_set)
  );

  always #5 clk = ~clk;

  // SIE model: token_done flag, token register, show-ahead OUT FIFO for ep0
  logic [7:0]  fifo_mem [16];
  int          wp = 0, rp = 0;
  logic        done = 1'b0, done_set = 1'b0, flush = 1'b0;
  logic [15:0] tok = 16'h0000;
  int          cyc = 0;

  always_comb begin
    io_din = 16'h0000;
    case (io_addr)
      A_STATUS:  io_din = {15'b0, done};
      A_TOKEN:   io_din = tok;
      A_EPO_CTL: io_din = {15'b0, (rp == wp)};
      A_EPO_DAT: io_din = {8'h00, fifo_mem[rp[3:0]]};
      default:   io_din = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done_set) done <= 1'b1;
    else if (io_wr && io_addr == A_STATUS && io_dout[0]) done <= 1'b0;
    if (flush) rp <= wp;
    else if (io_rd && io_addr == A_EPO_DAT && rp != wp) rp <= rp + 1;
  end

  int n_checks = 0, n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int n_sv = 0, n_se = 0, n_te = 0, n_as = 0, n_st = 0, n_act = 0, n_viol = 0, n_bm = 0;
  int poll_cyc = 0, sv_cyc = 0, arm_cyc = 0;

  always @(negedge clk) begin
    if (io_wr) begin
      if (exp_q.size() == 0) check("wr_unexpected", {io_addr, io_dout}, 32'h0);
      else check("wr_order", {io_addr, io_dout}, exp_q.pop_front());
    end
    if (setup_valid) begin n_sv++; sv_cyc = cyc; end
    if (setup_err)   n_se++;
    if (token_event) n_te++;
    if (addr_set)    n_as++;
    if (io_rd && io_addr == A_STATUS) begin n_st++; if (io_din[0]) poll_cyc = cyc; end
    if (io_wr && io_addr == A_EPI_CTL) arm_cyc = cyc;
    if (io_rd || io_wr) n_act++;
    if (!busy && (io_addr != 0 || io_rd || io_wr || io_dout != 0)) n_viol++;
    if (busy != (io_rd || io_wr)) n_bm++;
  end

  wire [110:0] all_out = {io_addr, io_rd, io_wr, io_dout, busy, setup_pending, setup_data,
                          setup_valid, setup_err, token_event, token_type, token_endp,
                          addr_pending, addr_set};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [71:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wp[3:0]] = b[8*i +: 8];
      wp++;
    end
  endtask

  task automatic post_token(input logic [15:0] t);
    tok = t;
    done_set = 1'b1;
    tick(1);
    done_set = 1'b0;
  endtask

  int s0, s1, s2, k;

  initial begin
    usb_reset = 1'b1; enable = 1'b0; setup_done = 1'b0;
    tick(3);
    check("reset_outputs", all_out, 111'd0);
    usb_reset = 1'b0;

    // idle polling cadence
    enable = 1'b1;
    tick(10);
    s0 = n_st; s1 = n_bm; s2 = n_viol;
    tick(50);
    check("poll_rate", n_st - s0, 10);
    check("poll_busy_only_read", n_bm - s1, 0);
    check("poll_idle_zero", n_viol - s2, 0);

    // SET_ADDRESS then status IN
    s0 = n_sv; s1 = n_se;
    load(72'h00_0000_0000_002A_0500, 8);
    exp_q.push_back({A_STATUS, 16'h0001});
    exp_q.push_back({A_EPI_CTL, 16'h0002});
    post_token(16'h0030);
    tick(40);
    check("sa_drain", exp_q.size(), 0);
    check("sa_addr_pending", addr_pending, 1'b1);
    check("sa_arm_latency", arm_cyc - poll_cyc, 21);
    check("sa_no_valid_err", (n_sv - s0) + (n_se - s1), 0);
    s0 = n_as; s1 = n_te;
    exp_q.push_back({A_STATUS, 16'h0001});
    exp_q.push_back({A_ADDRESS, 16'h002A});
    post_token(16'h0020);
    tick(20);
    check("sa_in_drain", exp_q.size(), 0);
    check("sa_addr_set", n_as - s0, 1);
    check("sa_addr_cleared", addr_pending, 1'b0);
    check("sa_no_token_event", n_te - s1, 0);

    // CPU-owned GET_DESCRIPTOR
    s0 = n_sv;
    load(72'h00_0012_0000_0100_0680, 8);
    exp_q.push_back({A_STATUS, 16'h0001});
    post_token(16'h0030);
    tick(40);
    check("cpu_valid", n_sv - s0, 1);
    check("cpu_valid_latency", sv_cyc - poll_cyc, 20);
    check("cpu_pending", setup_pending, 1'b1);
    check("cpu_data", setup_data, 64'h0012_0000_0100_0680);
    check("cpu_busy_low", busy, 1'b0);
    s0 = n_act;
    tick(20);
    check("cpu_hold_quiet", n_act - s0, 0);
    setup_done = 1'b1;
    tick(1);
    setup_done = 1'b0;
    s0 = n_st;
    tick(20);
    check("cpu_pending_clr", setup_pending, 1'b0);
    check("cpu_poll_resumes", (n_st - s0) > 0, 1'b1);
    check("cpu_drain", exp_q.size(), 0);

    // short (5 byte) and long (9 byte) SETUP
    for (int t = 0; t < 2; t++) begin
      s0 = n_se; s1 = n_sv;
      if (t == 0) load(72'h00_0000_0000_0100_0680, 5);
      else        load(72'hFF_0012_0000_0100_0680, 9);
      exp_q.push_back({A_STATUS, 16'h0001});
      exp_q.push_back({A_EPI_CTL, 16'h0004});
      post_token(16'h0030);
      tick(40);
      check(t == 0 ? "short_err" : "long_err", n_se - s0, 1);
      check(t == 0 ? "short_no_valid" : "long_no_valid", n_sv - s1, 0);
      check(t == 0 ? "short_pending" : "long_pending", setup_pending, 1'b0);
      check(t == 0 ? "short_drain" : "long_drain", exp_q.size(), 0);
      check(t == 0 ? "short_fifo_empty" : "long_fifo_empty", rp == wp, 1'b1);
    end

    // OUT on ep1 forwarded to CPU
    s0 = n_te;
    exp_q.push_back({A_STATUS, 16'h0001});
    post_token(16'h0011);
    tick(20);
    check("out_event", n_te - s0, 1);
    check("out_type_endp", {token_type, token_endp}, {2'b01, 4'd1});
    check("out_drain", exp_q.size(), 0);

    // reset during the 4th BYTE cycle
    load(72'h00_0000_0000_002A_0500, 8);
    exp_q.push_back({A_STATUS, 16'h0001});
    post_token(16'h0030);
    k = 0;
    for (int i = 0; i < 80 && k < 4; i++) begin
      if (io_rd && io_addr == A_EPO_DAT) k++;
      if (k < 4) tick(1);
    end
    check("rst_reached_byte4", k, 4);
    usb_reset = 1'b1; enable = 1'b0; flush = 1'b1;
    tick(1);
    usb_reset = 1'b0; flush = 1'b0;
    check("rst_outputs", all_out, 111'd0);
    check("rst_drain", exp_q.size(), 0);
    enable = 1'b1;
    s0 = n_as;
    load(72'h00_0000_0000_00FF_0500, 8);
    exp_q.push_back({A_STATUS, 16'h0001});
    exp_q.push_back({A_EPI_CTL, 16'h0002});
    post_token(16'h0030);
    tick(40);
    check("rst_sa_pending", addr_pending, 1'b1);
    exp_q.push_back({A_STATUS, 16'h0001});
    exp_q.push_back({A_ADDRESS, 16'h007F});
    post_token(16'h0020);
    tick(20);
    check("rst_sa_set", n_as - s0, 1);
    check("rst_sa_cleared", addr_pending, 1'b0);
    check("rst_sa_drain", exp_q.size(), 0);
    check("never_dirty_idle", n_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
